// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan monitor.
// Holds the 16 active-low segment patterns (bits {g,f,e,d,c,b,a}, lit = 0), the
// digit count, the capture FSM state encoding and two small helpers for the
// one-hot-low digit select.
package seg_pkg;

  localparam int unsigned NumDigits = 6;

  localparam logic [6:0] SegPat0 = 7'h40;
  localparam logic [6:0] SegPat1 = 7'h79;
  localparam logic [6:0] SegPat2 = 7'h24;
  localparam logic [6:0] SegPat3 = 7'h30;
  localparam logic [6:0] SegPat4 = 7'h19;
  localparam logic [6:0] SegPat5 = 7'h12;
  localparam logic [6:0] SegPat6 = 7'h02;
  localparam logic [6:0] SegPat7 = 7'h78;
  localparam logic [6:0] SegPat8 = 7'h00;
  localparam logic [6:0] SegPat9 = 7'h10;
  localparam logic [6:0] SegPatA = 7'h08;
  localparam logic [6:0] SegPatB = 7'h03;
  localparam logic [6:0] SegPatC = 7'h46;
  localparam logic [6:0] SegPatD = 7'h21;
  localparam logic [6:0] SegPatE = 7'h06;
  localparam logic [6:0] SegPatF = 7'h0E;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StHeld   = 2'd2
  } scan_state_e;

  // True when exactly one select bit is low.
  function automatic logic sel_valid(input logic [NumDigits-1:0] sel);
    logic [NumDigits-1:0] act;
    act = ~sel;
    return (act != '0) && ((act & (act - NumDigits'(1))) == '0);
  endfunction

  // Index of the low select bit; only meaningful when sel_valid() holds.
  function automatic logic [2:0] sel_index(input logic [NumDigits-1:0] sel);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < NumDigits; i++) begin
      if (!sel[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_pattern_decoder.sv
// Inverse seven-segment lookup.
// Ports:
//   pattern - active-low segment pattern {g,f,e,d,c,b,a}
//   value   - decoded hex digit (0 when the pattern is illegal)
//   illegal - pattern matches none of the 16 hex glyphs
module seg_pattern_decoder
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       illegal
);

  always_comb begin
    value   = 4'h0;
    illegal = 1'b0;
    case (pattern)
      SegPat0: value = 4'h0;
      SegPat1: value = 4'h1;
      SegPat2: value = 4'h2;
      SegPat3: value = 4'h3;
      SegPat4: value = 4'h4;
      SegPat5: value = 4'h5;
      SegPat6: value = 4'h6;
      SegPat7: value = 4'h7;
      SegPat8: value = 4'h8;
      SegPat9: value = 4'h9;
      SegPatA: value = 4'hA;
      SegPatB: value = 4'hB;
      SegPatC: value = 4'hC;
      SegPatD: value = 4'hD;
      SegPatE: value = 4'hE;
      SegPatF: value = 4'hF;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_monitor.sv
// Passive monitor for a multiplexed six-digit seven-segment display.
// Samples the scan lines, waits until a digit has been stable for STABLE_CYCLES
// synchronized cycles, decodes it and assembles full six-digit frames.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   seg_sel      - digit select, one-hot active-low, digit 0 most significant
//   seg_data     - segment drive, active-low, bit7 = dp
//   cap_valid    - one-cycle pulse per captured digit
//   cap_index    - index of the last captured digit
//   cap_nibble   - decoded value of the last captured digit
//   frame_valid  - one-cycle pulse when all six digits have been seen
//   frame_value  - digit i in bits [23-4i:20-4i]
//   frame_dp     - bit i set when digit i had its dp lit
//   frame_err    - some digit of the reported frame had an illegal pattern
module seg_scan_monitor
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  seg_sel,
  input  logic [7:0]  seg_data,
  output logic        cap_valid,
  output logic [2:0]  cap_index,
  output logic [3:0]  cap_nibble,
  output logic        frame_valid,
  output logic [23:0] frame_value,
  output logic [5:0]  frame_dp,
  output logic        frame_err
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);

  // Synchronizer and one-cycle history of the synchronized {sel, data} word.
  logic [13:0] sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= {seg_sel, seg_data};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  logic [5:0] sel_s;
  logic [7:0] data_s;
  assign sel_s  = sync2_q[13:8];
  assign data_s = sync2_q[7:0];

  logic [3:0] dec_value;
  logic       dec_illegal;

  seg_pattern_decoder u_decoder (
    .pattern (data_s[6:0]),
    .value   (dec_value),
    .illegal (dec_illegal)
  );

  // Capture FSM
  scan_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cap_fire;
  logic            changed, sel_ok;

  assign changed = (sync2_q != prev_q);
  assign sel_ok  = sel_valid(sel_s);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap_fire = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sel_ok) begin
          state_d = StSettle;
          cnt_d   = CntW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StSettle, StHeld: begin
        if (changed) begin
          if (sel_ok) begin
            state_d = StSettle;
            cnt_d   = CntW'(1);
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end else if (state_q == StSettle) begin
          if (cnt_q < CntMax) cnt_d = cnt_q + CntW'(1);
          if (cnt_d == CntMax) begin
            state_d  = StHeld;
            cap_fire = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Per-digit storage and frame assembly
  logic [2:0]                 cap_idx;
  logic [NumDigits-1:0]       seen_q, seen_d, err_q, err_d, dp_q, dp_d;
  logic [NumDigits-1:0][3:0]  nib_q, nib_d;
  logic                       frame_due;
  logic [23:0]                frame_value_d;

  assign cap_idx   = sel_index(sel_s);
  assign frame_due = &seen_q;

  always_comb begin
    // Clearing on the frame cycle first lets a coincident capture land in the next frame.
    seen_d = frame_due ? '0 : seen_q;
    err_d  = frame_due ? '0 : err_q;
    nib_d  = nib_q;
    dp_d   = dp_q;
    if (cap_fire) begin
      seen_d[cap_idx] = 1'b1;
      err_d[cap_idx]  = dec_illegal;
      nib_d[cap_idx]  = dec_value;
      dp_d[cap_idx]   = ~data_s[7];
    end
    frame_value_d = '0;
    for (int i = 0; i < NumDigits; i++) begin
      frame_value_d[23-4*i -: 4] = nib_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q      <= '0;
      err_q       <= '0;
      nib_q       <= '0;
      dp_q        <= '0;
      cap_valid   <= 1'b0;
      cap_index   <= '0;
      cap_nibble  <= '0;
      frame_valid <= 1'b0;
      frame_value <= '0;
      frame_dp    <= '0;
      frame_err   <= 1'b0;
    end else begin
      seen_q      <= seen_d;
      err_q       <= err_d;
      nib_q       <= nib_d;
      dp_q        <= dp_d;
      cap_valid   <= cap_fire;
      frame_valid <= frame_due;
      if (cap_fire) begin
        cap_index  <= cap_idx;
        cap_nibble <= dec_value;
      end
      if (frame_due) begin
        frame_value <= frame_value_d;
        frame_dp    <= dp_q;
        frame_err   <= |err_q;
      end
    end
  end

endmodule

// File: doc/seg_scan_monitor.md
SEG_SCAN_MONITOR -- requirements
Module: seg_scan_monitor

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16: consecutive identical synchronized samples required before a digit is captured; legal range 2..1023.
REQ-002 SHALL have port clk, input, 1: system clock.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port seg_sel, input, 6: digit select, one-hot active-low; bit i low selects digit i, where digit 0 is the most significant.
REQ-005 SHALL have port seg_data, input, 8: segment drive, active-low; bit7 = dp, bits6..0 = {g,f,e,d,c,b,a}.
REQ-006 SHALL have port cap_valid, output, 1: one-cycle pulse when a digit is captured.
REQ-007 SHALL have port cap_index, output, 3: digit index of the last capture (0..5).
REQ-008 SHALL have port cap_nibble, output, 4: decoded value of the last capture.
REQ-009 SHALL have port frame_valid, output, 1: one-cycle pulse when all six digits have been captured.
REQ-010 SHALL have port frame_value, output, 24: digit i held in bits [23-4i:20-4i].
REQ-011 SHALL have port frame_dp, output, 6: bit i = 1 when the dp of digit i was lit (seg_data[7] = 0).
REQ-012 SHALL have port frame_err, output, 1: at least one digit in the reported frame carried an illegal segment pattern.

Function
REQ-013 SHALL pass seg_sel and seg_data through a 2-flop synchronizer before any other use.
REQ-014 SHALL decode the pattern as inverse hex, with patterns given as hex of bits6..0 and value→pattern pairs as follows:
- 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
- 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
REQ-015 SHALL treat any other pattern as illegal, record nibble 0, and set the per-digit error bit.
REQ-016 SHALL implement an FSM with states IDLE, SETTLE and HELD.
REQ-017 IDLE: the synchronized seg_sel has zero or more than one low bit; no capture occurs.
REQ-018 IDLE→SETTLE when the synchronized seg_sel is valid one-hot-low; the stability counter loads 1.
REQ-019 SETTLE: the counter increments while the synchronized {seg_sel, seg_data} is unchanged from the previous cycle.
REQ-020 SETTLE: any change reloads the counter to 1 if the new seg_sel is valid, otherwise the FSM goes to IDLE.
REQ-021 SETTLE→HELD on the cycle the counter reaches STABLE_CYCLES; cap_valid, cap_index and cap_nibble are registered on that cycle.
REQ-022 HELD: no further capture while the inputs are unchanged; any change exits to SETTLE or IDLE per REQ-020.
REQ-023 Capture latency SHALL be 2 synchronizer cycles + STABLE_CYCLES after the inputs settle.
REQ-024 On each capture, SHALL store the nibble, dp and error bit for that index and set seen[index]; recapturing an already-seen index overwrites its data and leaves seen unchanged.
REQ-025 When seen becomes 6'b111111, the cycle after that capture SHALL:
- pulse frame_valid;
- update frame_value and frame_dp;
- set frame_err to the OR of the error bits.
REQ-026 On that same cycle, seen and the error bits SHALL clear.
REQ-027 frame_* outputs SHALL hold their values between frames.
REQ-028 A capture coinciding with the frame_valid cycle SHALL count toward the next frame.
REQ-029 The stability counter SHALL saturate at STABLE_CYCLES, never wrap, and be $clog2(STABLE_CYCLES+1) bits wide.

Reset
REQ-030 On rst_n low, SHALL asynchronously:
- set the synchronizers to all-ones (no select, segments off);
- put the FSM in IDLE and clear the counter, seen, the error bits and stored digits;
- set cap_valid = 0, cap_index = 0, cap_nibble = 0;
- set frame_valid = 0, frame_value = 0, frame_dp = 0, frame_err = 0.
REQ-031 Reset asserted mid-frame SHALL discard partial data; after release, no frame_valid until six fresh captures occur.

Structure
REQ-032 Shared package seg_pkg SHALL hold the 16 segment pattern constants, the digit count (6) and the FSM state encoding.
REQ-033 The inverse lookup SHALL be one combinational sub-module seg_pattern_decoder (7-bit pattern → 4-bit value + illegal flag).

Verification
REQ-034 Verification scenarios (STABLE_CYCLES = 16):
- Drive the scan of 123456 (digit0 = 1), each digit held 40 cycles → six cap_valid pulses, then frame_valid with frame_value = 24'h123456, frame_err = 0.
- Digit held only 10 cycles, then changed → no cap_valid for that digit.
- Digit 2 pattern 7F (blank) within a full scan → frame_err = 1, frame_value[15:12] = 0.
- seg_sel = 6'b111100 held 50 cycles → no capture, FSM in IDLE.
- dp lit on digit 3 only → frame_dp = 6'b001000.
- rst_n pulsed after 4 captures, then full scan of ABCDEF → a single frame_valid with 24'hABCDEF.
